// File: rtl/fifo_reader_if.sv
// Bus bundle between the FIFO read port, the drain engine and the stream consumer.
// The master side belongs to the drain engine; the slave side is the environment
// made of the FIFO read port plus the downstream consumer.
interface fifo_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        input  m_ready,
        output fifo_rd_en,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        output m_ready,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/fifo_reader.sv
// Read-side drain engine for the 32-bit FIFO.
// Issues read strobes, catches the word returned one clock later in a two-entry
// skid buffer and presents the buffered words in order on a valid/ready stream.
// A read is only issued when a buffer slot is guaranteed to be free by the time
// its data returns, so the buffer can never overflow.
module fifo_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    output logic [CNT_WIDTH-1:0] word_cnt,
    fifo_reader_if.master        bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    occ_t                  occ;
    occ_t                  occ_next;
    logic                  inflight;
    logic                  inflight_next;
    logic                  drop;
    logic                  drop_next;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] head_next;
    logic [DATA_WIDTH-1:0] tail;
    logic [DATA_WIDTH-1:0] tail_next;
    logic [CNT_WIDTH-1:0]  cnt_next;
    logic [1:0]            committed;
    logic                  pop;
    logic                  push;
    logic                  rd_en;

    // Stream side view of the buffer and the read-strobe decision.
    always_comb begin
        committed = 2'(occ) + {1'b0, inflight};
        pop       = (occ != EMPTY) && bus.m_ready;
        push      = inflight && !drop && !flush;
        rd_en     = !bus.fifo_empty && !flush && !reset && ((committed < 2'd2) || pop);
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = (occ != EMPTY);
    assign bus.m_data     = (occ != EMPTY) ? head : '0;

    // Next buffer contents: flush discards everything, otherwise push/pop
    // shift words through head/tail while keeping arrival order.
    always_comb begin
        occ_next      = occ;
        head_next     = head;
        tail_next     = tail;
        inflight_next = rd_en;
        drop_next     = 1'b0;
        cnt_next      = word_cnt + {{(CNT_WIDTH-1){1'b0}}, pop};
        if (flush) begin
            occ_next  = EMPTY;
            head_next = '0;
            tail_next = '0;
            drop_next = inflight;
        end else begin
            case (occ)
                EMPTY: begin
                    if (push) begin
                        head_next = bus.fifo_rd_data;
                        occ_next  = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_next = bus.fifo_rd_data;
                    end else if (push) begin
                        tail_next = bus.fifo_rd_data;
                        occ_next  = TWO;
                    end else if (pop) begin
                        head_next = '0;
                        occ_next  = EMPTY;
                    end
                end
                TWO: begin
                    if (push && pop) begin
                        head_next = tail;
                        tail_next = bus.fifo_rd_data;
                    end else if (pop) begin
                        head_next = tail;
                        tail_next = '0;
                        occ_next  = ONE;
                    end
                end
                default: begin
                    occ_next  = EMPTY;
                    head_next = '0;
                    tail_next = '0;
                end
            endcase
        end
    end

    // State register; reset drops buffered and in-flight words alike.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ      <= EMPTY;
            inflight <= 1'b0;
            drop     <= 1'b0;
            head     <= '0;
            tail     <= '0;
            word_cnt <= '0;
        end else begin
            occ      <= occ_next;
            inflight <= inflight_next;
            drop     <= drop_next;
            head     <= head_next;
            tail     <= tail_next;
            word_cnt <= cnt_next;
        end
    end

endmodule
